mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the combinational execute stage; contains the EX/MEM pipeline register.
- ALU-only instructions pass to write-back with one registered cycle.
- Loads and stores run a request/acknowledge transaction on the data bus and stall the upstream pipeline until the transaction completes or times out.
- Feeds the write-back stage: register address, write data and write enable.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_bus_ctrl.sv | 107 ++++++++++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access kinds and bus FSM states.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    RWE_NONE  = 2'b00,
    RWE_REG   = 2'b01,
    RWE_LOAD  = 2'b10,
    RWE_STORE = 2'b11
  } rwe_e;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_st_e;

  // LOAD and STORE are the only kinds with the upper bit set.
  function automatic logic is_mem_op(input logic [1:0] rwe);
    return rwe[1];
  endfunction

endpackage

// File: rtl/mem_stage_bus_ctrl.sv
// Data-bus request/acknowledge controller: FSM, timeout counter, bus registers,
// upstream stall and completion/error strobes.
module mem_bus_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              bus_ack_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_st_e           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              timeout_hit;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = (state_q == MEM_ST_WAIT) && !bus_ack_i &&
                           (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_ST_IDLE: if (start_i) state_d = MEM_ST_WAIT;
      MEM_ST_WAIT: if (bus_ack_i || timeout_hit) state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase
  end

  // Bus registers only load on entry to WAIT so they stay stable for the whole transaction.
  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == MEM_ST_IDLE) begin
      if (start_i) begin
        cnt_d   = '0;
        req_d   = 1'b1;
        we_d    = we_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
      end
    end else if (bus_ack_i || timeout_hit) begin
      req_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy_o  = (state_q == MEM_ST_WAIT);
    done_o  = busy_o && bus_ack_i;
    err_o   = timeout_hit;
    stall_o = (!busy_o && start_i) || (busy_o && !bus_ack_i && !timeout_hit);
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM pipeline register and write-back mux around
// the data-bus controller.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memi_valid,
  input  logic [15:0]           memi_instr,
  input  logic [15:0]           memi_pc,
  input  logic [DATA_W-1:0]     memi_result,
  input  logic [REG_ADDR_W-1:0] memi_wreg_addr,
  input  logic [DATA_W-1:0]     memi_write_to_mem_data,
  input  logic [1:0]            memi_rwe,
  input  logic                  memi_branch,
  output logic                  memo_stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  memo_valid,
  output logic [15:0]           memo_instr,
  output logic [15:0]           memo_pc,
  output logic [REG_ADDR_W-1:0] memo_wreg_addr,
  output logic [DATA_W-1:0]     memo_wdata,
  output logic                  memo_wen,
  output logic                  memo_branch,
  output logic                  memo_bus_err
);

  logic start, busy, done, err;

  logic                  valid_q, valid_d;
  logic                  wen_q, wen_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           pc_q, pc_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  branch_q, branch_d;
  logic                  bus_err_q, bus_err_d;

  assign start = memi_valid && is_mem_op(memi_rwe);

  mem_bus_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) u_bus_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .we_i       (memi_rwe == RWE_STORE),
    .addr_i     (memi_result[ADDR_W-1:0]),
    .wdata_i    (memi_write_to_mem_data),
    .bus_ack_i  (bus_ack),
    .stall_o    (memo_stall),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .bus_req_o  (bus_req),
    .bus_we_o   (bus_we),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      branch_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      branch_q  <= branch_d;
      bus_err_q <= bus_err_d;
    end
  end

  // While busy the captured instruction is held; upstream keeps re-presenting it.
  always_comb begin
    valid_d   = 1'b0;
    wen_d     = 1'b0;
    instr_d   = instr_q;
    pc_d      = pc_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    branch_d  = branch_q;
    bus_err_d = 1'b0;
    if (!busy) begin
      instr_d  = memi_instr;
      pc_d     = memi_pc;
      wreg_d   = memi_wreg_addr;
      branch_d = memi_branch;
      valid_d  = memi_valid && !start;
      if (memi_valid && memi_rwe == RWE_REG) begin
        wen_d   = 1'b1;
        wdata_d = memi_result;
      end
    end else if (done) begin
      valid_d = 1'b1;
      if (!bus_we) begin
        wen_d   = 1'b1;
        wdata_d = bus_rdata;
      end
    end else if (err) begin
      valid_d   = 1'b1;
      bus_err_d = 1'b1;
    end
  end

  assign memo_valid     = valid_q;
  assign memo_wen       = wen_q;
  assign memo_instr     = instr_q;
  assign memo_pc        = pc_q;
  assign memo_wreg_addr = wreg_q;
  assign memo_wdata     = wdata_q;
  assign memo_branch    = branch_q;
  assign memo_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then random ops, with
// expectations derived from ack delay versus timeout.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memi_valid;
  logic [15:0] memi_instr, memi_pc, memi_result, memi_write_to_mem_data;
  logic [3:0]  memi_wreg_addr;
  logic [1:0]  memi_rwe;
  logic        memi_branch;
  logic        memo_stall, bus_req, bus_we, bus_ack;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        memo_valid, memo_wen, memo_branch, memo_bus_err;
  logic [15:0] memo_instr, memo_pc, memo_wdata;
  logic [3:0]  memo_wreg_addr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.DATA_W(16), .ADDR_W(16), .REG_ADDR_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memi_valid(memi_valid), .memi_instr(memi_instr), .memi_pc(memi_pc),
    .memi_result(memi_result), .memi_wreg_addr(memi_wreg_addr),
    .memi_write_to_mem_data(memi_write_to_mem_data), .memi_rwe(memi_rwe),
    .memi_branch(memi_branch), .memo_stall(memo_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .memo_valid(memo_valid), .memo_instr(memo_instr), .memo_pc(memo_pc),
    .memo_wreg_addr(memo_wreg_addr), .memo_wdata(memo_wdata), .memo_wen(memo_wen),
    .memo_branch(memo_branch), .memo_bus_err(memo_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One instruction through the stage. For memory ops, ack arrives in WAIT cycle k
  // (k=0 is same-cycle); k >= TO means the bus never answers in time.
  task automatic do_op(input logic vld, input logic [1:0] rwe, input logic [15:0] res,
                       input logic [15:0] sdata, input logic [3:0] wr, input int k,
                       input logic [15:0] rd);
    logic [15:0] instr, pc, exp_rd;
    logic        br, is_mem, timed_out, fin;
    instr = 16'($urandom); pc = 16'($urandom); br = 1'($urandom);
    is_mem = vld && rwe[1];
    timed_out = is_mem && (k > TO - 1);
    exp_rd = 16'h0;
    memi_valid = vld; memi_rwe = rwe; memi_result = res; memi_write_to_mem_data = sdata;
    memi_wreg_addr = wr; memi_instr = instr; memi_pc = pc; memi_branch = br;
    if (!is_mem) begin
      bus_ack = 1'($urandom);
      @(negedge clk);
      check("alu_stall", memo_stall, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check("alu_valid", memo_valid, vld);
      check("alu_wen", memo_wen, vld && rwe == 2'b01);
      if (vld && rwe == 2'b01) begin
        check("alu_wdata", memo_wdata, res);
        check("alu_wreg", memo_wreg_addr, wr);
      end
      check("alu_req", bus_req, 0);
      check("alu_err", memo_bus_err, 0);
    end else begin
      bus_ack = 1'b0;
      @(negedge clk);
      check("idle_stall", memo_stall, 1);
      check("idle_req", bus_req, 0);
      @(posedge clk); #1;
      for (int w = 0; w < TO; w++) begin
        bus_ack = (w == k);
        bus_rdata = (w == k) ? rd : 16'($urandom);
        if (w == k) exp_rd = rd;
        @(negedge clk);
        check("wait_req", bus_req, 1);
        check("wait_addr", bus_addr, res);
        check("wait_we", bus_we, rwe == 2'b11);
        if (rwe == 2'b11) check("wait_wdata", bus_wdata, sdata);
        check("wait_valid", memo_valid, 0);
        if (w == 0) check("wait_err", memo_bus_err, 0);
        check("wait_stall", memo_stall, (w < k) && (w < TO - 1));
        fin = (w == k) || (w == TO - 1);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        if (fin) break;
      end
      check("done_valid", memo_valid, 1);
      check("done_wen", memo_wen, rwe == 2'b10 && !timed_out);
      if (rwe == 2'b10 && !timed_out) begin
        check("done_wdata", memo_wdata, exp_rd);
        check("done_wreg", memo_wreg_addr, wr);
      end
      check("done_err", memo_bus_err, timed_out);
      check("done_req", bus_req, 0);
    end
    check("instr", memo_instr, instr);
    check("pc", memo_pc, pc);
    check("branch", memo_branch, br);
  endtask

  initial begin
    rst_n = 1'b0; memi_valid = 1'b0; memi_instr = '0; memi_pc = '0; memi_result = '0;
    memi_wreg_addr = '0; memi_write_to_mem_data = '0; memi_rwe = 2'b00; memi_branch = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", bus_req, 0);
    check("rst_valid", memo_valid, 0);
    check("rst_err", memo_bus_err, 0);
    check("rst_stall", memo_stall, 0);
    rst_n = 1'b1;

    do_op(1'b1, 2'b01, 16'h1234, 16'h0, 4'd3, 0, 16'h0);
    do_op(1'b1, 2'b10, 16'h0040, 16'h0, 4'd5, 3, 16'hBEEF);
    do_op(1'b1, 2'b11, 16'h0010, 16'h00AA, 4'd1, 0, 16'h0);
    do_op(1'b1, 2'b10, 16'h0020, 16'h0, 4'd7, 100, 16'h0);
    do_op(1'b0, 2'b00, 16'h0, 16'h0, 4'd0, 0, 16'h0);

    // Reset in the middle of a load transaction.
    memi_valid = 1'b1; memi_rwe = 2'b10; memi_result = 16'h0099; memi_instr = 16'hABCD;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", bus_req, 1);
    rst_n = 1'b0; memi_valid = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_valid", memo_valid, 0);
    check("mid_rst_wen", memo_wen, 0);
    check("mid_rst_wdata", memo_wdata, 0);
    check("mid_rst_instr", memo_instr, 0);
    check("mid_rst_stall", memo_stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1'b1, 2'b01, 16'h5A5A, 16'h0, 4'd9, 0, 16'h0);

    do_op(1'b1, 2'b10, 16'h0100, 16'h0, 4'd2, TO - 1, 16'h1357);
    do_op(1'b1, 2'b11, 16'h0104, 16'hCAFE, 4'd2, TO - 1, 16'h0);

    for (int i = 0; i < 60; i++) begin
      do_op($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
            16'($urandom), 4'($urandom), int'($urandom_range(0, TO + 1)), 16'($urandom));
    end

    memi_valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
